muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit for the RV32M extension. It is the sequential companion to the

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
// Shift-add multiply and restoring divide on magnitudes; signs are applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic             a_neg_r;
  logic             b_neg_r;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             a_signed_in, b_signed_in, a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic             dbz_in, ovf_in, special_in;
  logic [WIDTH-1:0] special_res;

  // Operand decode at accept: signedness per funct3, magnitudes and special cases
  always_comb begin
    a_signed_in = 1'b0;
    b_signed_in = 1'b0;
    if (op[2]) begin
      a_signed_in = !op[0];
      b_signed_in = !op[0];
    end else begin
      a_signed_in = (op != 3'b011);
      b_signed_in = !op[1];
    end
    a_neg_in    = a_signed_in && a[WIDTH-1];
    b_neg_in    = b_signed_in && b[WIDTH-1];
    a_mag_in    = a_neg_in ? -a : a;
    b_mag_in    = b_neg_in ? -b : b;
    dbz_in      = op[2] && (b == '0);
    ovf_in      = op[2] && !op[0] && (b != '0) &&
                  (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    special_in  = dbz_in || ovf_in;
    special_res = '0;
    if (dbz_in)
      special_res = op[1] ? a : '1;
    else if (ovf_in)
      special_res = op[1] ? '0 : a;
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rs;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    div_rs   = {hi, lo[WIDTH-1]};
    div_ge   = (div_rs >= {1'b0, b_mag});
    div_diff = div_rs[WIDTH-1:0] - b_mag;
  end

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_res;

  // Sign correction: product negated on differing signs, quotient likewise, remainder follows dividend
  always_comb begin
    prod_s  = (a_neg_r ^ b_neg_r) ? -{hi, lo} : {hi, lo};
    fix_res = '0;
    if (op_r[2]) begin
      if (op_r[1])
        fix_res = a_neg_r ? -hi : hi;
      else
        fix_res = (a_neg_r ^ b_neg_r) ? -lo : lo;
    end else begin
      fix_res = (op_r[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      cnt       <= '0;
      op_r      <= '0;
      a_neg_r   <= 1'b0;
      b_neg_r   <= 1'b0;
      b_mag     <= '0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r     <= op;
            a_neg_r  <= a_neg_in;
            b_neg_r  <= b_neg_in;
            b_mag    <= b_mag_in;
            hi       <= '0;
            lo       <= a_mag_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (special_in) begin
              result    <= special_res;
              flags     <= {special_res == '0, special_res[WIDTH-1], dbz_in, ovf_in};
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op_r[2]) begin
            hi <= div_ge ? div_diff : div_rs[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1))
            state <= FIX;
        end
        FIX: begin
          result    <= fix_res;
          flags     <= {fix_res == '0, fix_res[WIDTH-1], 2'b00};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit with a 64-bit arithmetic reference
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Returns {zero, sign, div_by_zero, div_overflow, result}
  function automatic logic [35:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xs, ys, xu, yu, p;
    logic [31:0] r;
    logic        dz, ov;
    xs = {{32{x[31]}}, x};
    ys = {{32{y[31]}}, y};
    xu = {32'b0, x};
    yu = {32'b0, y};
    dz = 1'b0;
    ov = 1'b0;
    r  = 32'b0;
    p  = 64'b0;
    case (o)
      3'd0: begin p = xs * ys; r = p[31:0];  end
      3'd1: begin p = xs * ys; r = p[63:32]; end
      3'd2: begin p = xs * yu; r = p[63:32]; end
      3'd3: begin p = xu * yu; r = p[63:32]; end
      3'd4: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = x; ov = 1'b1; end
        else r = $signed(x) / $signed(y);
      end
      3'd5: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
        else r = x / y;
      end
      3'd6: begin
        if (y == 0) begin r = x; dz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = 32'b0; ov = 1'b1; end
        else r = $signed(x) % $signed(y);
      end
      default: begin
        if (y == 0) begin r = x; dz = 1'b1; end
        else r = x % y;
      end
    endcase
    return {r == 32'b0, r[31], dz, ov, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Entered and left #1 after a rising edge with the unit idle
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit dir, input logic [31:0] er, input logic [3:0] ef);
    logic [35:0] m;
    int lat;
    int explat;
    m      = model(o, x, y);
    explat = is_special(o, x, y) ? 1 : 34;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(explat));
    check("result", result, m[31:0]);
    check("flags", flags, m[35:32]);
    if (dir) begin
      check("dir_result", result, er);
      check("dir_flags", flags, ef);
    end
    check("in_ready_done", in_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_clear", out_valid, 1'b0);
    check("in_ready_idle", in_ready, 1'b1);
  endtask

  initial begin
    bit seen;
    int waitc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_flags", flags, 4'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1'b1);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 4'b0100);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 4'b0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 4'b0100);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFF, 4'b0100);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 4'b0100);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 4'b0100);
    run_op(3'd5, 32'd100, 32'd7, 1, 32'd14, 4'b0000);
    run_op(3'd7, 32'd100, 32'd7, 1, 32'd2, 4'b0000);
    run_op(3'd6, 32'd6, 32'd3, 1, 32'd0, 4'b1000);
    run_op(3'd4, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 4'b0110);
    run_op(3'd6, 32'd5, 32'd0, 1, 32'd5, 4'b0010);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 4'b0101);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 4'b1001);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 0, 32'h0, 4'h0);

    // Hold in DONE with in_valid asserted; nothing may move
    op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; in_valid = 1'b1;
    @(posedge clk); #1;
    waitc = 0;
    while (!out_valid && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("hold_reach_done", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, 32'hFFFF_FFEB);
      check("hold_flags", flags, 4'b0100);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1'b1);
    check("release_out_valid", out_valid, 1'b0);
    check("idle_result_held", result, 32'hFFFF_FFEB);

    // Flush and in_valid in the same idle cycle: nothing accepted
    op = 3'd5; a = 32'd9; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept", in_ready, 1'b1);

    // Flush in cycle k+5 of a DIV
    op = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_calc_busy", in_ready, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("flush_no_result", seen, 1'b0);
    check("flush_result_kept", result, 32'hFFFF_FFEB);

    // Asynchronous reset in the middle of CALC
    op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_in_ready", in_ready, 1'b1);
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_result", result, 32'h0);
    check("async_rst_flags", flags, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(3'd5, 32'd9, 32'd2, 1, 32'd4, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
